// File: rtl/sipo_reg_beh.sv
// sipo_reg_beh: serial-in/parallel-out shift register with frame counting and a per-word valid pulse.
// Optional registered even-parity output is enabled by defining SIPO_PARITY_EN.
module sipo_reg_beh #(
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       data_in,
   output logic [WIDTH-1:0]           data_out,
   output logic                       data_valid,
   output logic [$clog2(WIDTH)-1:0]   bit_count
`ifdef SIPO_PARITY_EN
   ,
   output logic                       parity_out
`endif
);
   localparam int CW = $clog2(WIDTH);
   logic [WIDTH-1:0] r_data;
   logic [CW-1:0]    r_cnt;
   logic             r_valid;
   logic [WIDTH-1:0] w_next;
   logic             w_wrap;
   logic [CW-1:0]    w_cnt_next;
   always_comb begin
      w_next     = {r_data[WIDTH-2:0], data_in};
      w_wrap     = r_cnt == CW'(WIDTH - 1);
      w_cnt_next = w_wrap ? '0 : r_cnt + CW'(1);
   end
   // Reset (active-low) wins over the shift, discarding any partial frame.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_data  <= RESET_VALUE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_data  <= w_next;
         r_cnt   <= w_cnt_next;
         r_valid <= w_wrap;
      end
   end
`ifdef SIPO_PARITY_EN
   logic r_parity;
   always_ff @(posedge clk) begin
      if (!rst) r_parity <= ^RESET_VALUE;
      else      r_parity <= ^w_next;
   end
   assign parity_out = r_parity;
`endif
   assign data_out   = r_data;
   assign bit_count  = r_cnt;
   assign data_valid = r_valid;
endmodule

// File: tb/tb_sipo_reg_beh.sv
// tb_sipo_reg_beh: directed-vector bench for sipo_reg_beh (WIDTH=4, RESET_VALUE=0).
// Parity checks are compiled in only when SIPO_PARITY_EN is defined.
module tb_sipo_reg_beh;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       data_in = 1'b0;
   logic [3:0] data_out;
   logic       data_valid;
   logic [1:0] bit_count;
`ifdef SIPO_PARITY_EN
   logic       parity_out;
`endif
   int n_vec = 0;
   int n_err = 0;
   sipo_reg_beh #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .bit_count  (bit_count)
`ifdef SIPO_PARITY_EN
      ,
      .parity_out (parity_out)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // Drive one edge (inputs set on the falling edge), then check just after the rising edge.
   task automatic vec(input string tag, input logic d, input logic r,
                      input logic [3:0] e_data, input logic [1:0] e_cnt, input logic e_valid);
      @(negedge clk);
      data_in = d;
      rst     = r;
      @(posedge clk);
      #1;
      chk({tag, ".data"},  32'(data_out),   32'(e_data));
      chk({tag, ".cnt"},   32'(bit_count),  32'(e_cnt));
      chk({tag, ".valid"}, 32'(data_valid), 32'(e_valid));
   endtask
   initial begin
      vec("reset", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
`ifdef SIPO_PARITY_EN
      chk("reset.parity", 32'(parity_out), 32'd0);
`endif
      vec("frame1", 1'b1, 1'b1, 4'b0001, 2'd1, 1'b0);
      vec("frame2", 1'b0, 1'b1, 4'b0010, 2'd2, 1'b0);
      vec("frame3", 1'b1, 1'b1, 4'b0101, 2'd3, 1'b0);
      vec("frame4", 1'b1, 1'b1, 4'b1011, 2'd0, 1'b1);
`ifdef SIPO_PARITY_EN
      chk("frame4.parity", 32'(parity_out), 32'd1);
`endif
      vec("strm1", 1'b1, 1'b1, 4'b0111, 2'd1, 1'b0);
      vec("strm2", 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0);
      vec("strm3", 1'b0, 1'b1, 4'b1110, 2'd3, 1'b0);
      vec("strm4", 1'b0, 1'b1, 4'b1100, 2'd0, 1'b1);
`ifdef SIPO_PARITY_EN
      chk("strm4.parity", 32'(parity_out), 32'd0);
`endif
      vec("strm5", 1'b1, 1'b1, 4'b1001, 2'd1, 1'b0);
      vec("strm6", 1'b0, 1'b1, 4'b0010, 2'd2, 1'b0);
      vec("strm7", 1'b1, 1'b1, 4'b0101, 2'd3, 1'b0);
      vec("strm8", 1'b0, 1'b1, 4'b1010, 2'd0, 1'b1);
      vec("mid1",  1'b1, 1'b1, 4'b0101, 2'd1, 1'b0);
      vec("mid2",  1'b1, 1'b1, 4'b1011, 2'd2, 1'b0);
      vec("midrst", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
      vec("mid3",  1'b0, 1'b1, 4'b0000, 2'd1, 1'b0);
      vec("mid4",  1'b1, 1'b1, 4'b0001, 2'd2, 1'b0);
      vec("mid5",  1'b1, 1'b1, 4'b0011, 2'd3, 1'b0);
      vec("mid6",  1'b0, 1'b1, 4'b0110, 2'd0, 1'b1);
      vec("col1",  1'b1, 1'b1, 4'b1101, 2'd1, 1'b0);
      vec("col2",  1'b1, 1'b1, 4'b1011, 2'd2, 1'b0);
      vec("col3",  1'b1, 1'b1, 4'b0111, 2'd3, 1'b0);
      vec("colrst", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
      vec("ovf1",  1'b1, 1'b1, 4'b0001, 2'd1, 1'b0);
      vec("ovf2",  1'b1, 1'b1, 4'b0011, 2'd2, 1'b0);
      vec("ovf3",  1'b1, 1'b1, 4'b0111, 2'd3, 1'b0);
      vec("ovf4",  1'b1, 1'b1, 4'b1111, 2'd0, 1'b1);
      vec("ovf5",  1'b1, 1'b1, 4'b1111, 2'd1, 1'b0);
      vec("ovf6",  1'b1, 1'b1, 4'b1111, 2'd2, 1'b0);
      vec("ovf7",  1'b1, 1'b1, 4'b1111, 2'd3, 1'b0);
      vec("ovf8",  1'b1, 1'b1, 4'b1111, 2'd0, 1'b1);
`ifdef SIPO_PARITY_EN
      chk("ovf8.parity", 32'(parity_out), 32'd0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
